// File: rtl/multi_colour_tracker.sv
// Colour-dominance pixel classifier with a 2-stage mark/highlight pipeline,
// per-class pixel counts and column centroids from a sequential restoring divider.
module multi_colour_tracker #(
    parameter  int CHAN_BITS   = 4,
    parameter  int NUM_CLASSES = 3,
    parameter  int IMG_W       = 320,
    parameter  int CNT_W       = 17,
    localparam int XW          = $clog2(IMG_W),
    localparam int SW          = CNT_W + XW,
    localparam int PW          = 3 * CHAN_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sop,
    input  logic                         in_eop,
    input  logic [PW-1:0]                in_data,
    input  logic [CHAN_BITS-1:0]         thresh,
    input  logic [NUM_CLASSES-1:0]       class_en,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [PW-1:0]                out_data,
    output logic [NUM_CLASSES*CNT_W-1:0] counts,
    output logic [NUM_CLASSES*XW-1:0]    centroid_x,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int CIW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int BW  = $clog2(SW);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    function automatic logic [CHAN_BITS-1:0] chan(input logic [PW-1:0] px, input int k);
        return px[(2-k)*CHAN_BITS +: CHAN_BITS];
    endfunction

    // Compared one bit wider so channel+thresh can never wrap.
    function automatic logic dominant(input logic [PW-1:0] px, input logic [CHAN_BITS-1:0] t,
                                      input int k);
        logic [CHAN_BITS:0] ref_v;
        logic               ok;
        ok = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j != k) begin
                ref_v = {1'b0, chan(px, j)} + {1'b0, t};
                if ({1'b0, chan(px, k)} <= ref_v) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    logic [NUM_CLASSES-1:0] w_cls;
    logic                   r1_valid, r1_sop, r1_eop;
    logic [PW-1:0]          r1_data;
    logic [NUM_CLASSES-1:0] r1_cls;
    logic [1:0]             r1_mode;
    logic                   r2_valid, r2_sop, r2_eop;
    logic [PW-1:0]          r2_data;
    logic [PW-1:0]          w_mask, w_px_out;

    assign in_ready = out_ready;

    // NOTE: every variable an always_comb writes gets a default first, so no path infers a latch.
    always_comb begin
        w_cls = '0;
        for (int k = 0; k < NUM_CLASSES; k++)
            w_cls[k] = class_en[k] & dominant(in_data, thresh, k);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_sop   <= 1'b0;
            r1_eop   <= 1'b0;
            r1_data  <= '0;
            r1_cls   <= '0;
            r1_mode  <= '0;
            r2_valid <= 1'b0;
            r2_sop   <= 1'b0;
            r2_eop   <= 1'b0;
            r2_data  <= '0;
        end else if (out_ready) begin
            r1_valid <= in_valid;
            r1_sop   <= in_valid & in_sop;
            r1_eop   <= in_valid & in_eop;
            r1_data  <= in_data;
            r1_cls   <= in_valid ? w_cls : '0;
            r1_mode  <= mode;
            r2_valid <= r1_valid;
            r2_sop   <= r1_sop;
            r2_eop   <= r1_eop;
            r2_data  <= w_px_out;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NUM_CLASSES; k++)
            if (r1_cls[k]) w_mask[(2-k)*CHAN_BITS +: CHAN_BITS] = '1;
    end

    always_comb begin
        case (r1_mode)
            2'd1:    w_px_out = w_mask;
            2'd2:    w_px_out = (|r1_cls) ? w_mask : r1_data;
            default: w_px_out = r1_data;
        endcase
    end

    assign out_valid = r2_valid;
    assign out_sop   = r2_sop;
    assign out_eop   = r2_eop;
    assign out_data  = r2_data;

    // Statistics are taken from stage 1 as it advances, so a stall holds them too.
    logic          w_acc, w_eop_evt;
    logic [XW-1:0] r_x, w_x_cur, w_x_nxt;
    logic [CNT_W-1:0] r_cnt [NUM_CLASSES];
    logic [SW-1:0]    r_sum [NUM_CLASSES];
    logic [CNT_W-1:0] w_cnt_new [NUM_CLASSES];
    logic [SW-1:0]    w_sum_new [NUM_CLASSES];
    logic [CNT_W-1:0] r_snap_cnt [NUM_CLASSES];
    logic [SW-1:0]    r_snap_sum [NUM_CLASSES];

    assign w_acc     = out_ready & r1_valid;
    assign w_eop_evt = w_acc & r1_eop;
    assign w_x_cur   = r1_sop ? '0 : r_x;
    assign w_x_nxt   = (w_x_cur == XW'(IMG_W - 1)) ? '0 : w_x_cur + XW'(1);

    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            w_cnt_new[k] = r1_sop ? '0 : r_cnt[k];
            w_sum_new[k] = r1_sop ? '0 : r_sum[k];
            if (r1_cls[k]) begin
                if (w_cnt_new[k] != '1) w_cnt_new[k] = w_cnt_new[k] + CNT_W'(1);
                w_sum_new[k] = w_sum_new[k] + SW'(w_x_cur);
            end
        end
    end

    state_t r_state, w_state_nxt;
    logic   w_div_run, w_latch, w_drop, w_snap;

    assign w_snap = w_eop_evt & (r_state != S_DIV);

    // NOTE: the per-class arrays are plain flops, not RAM, so they reset like any other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_cnt[k]      <= '0;
                r_sum[k]      <= '0;
                r_snap_cnt[k] <= '0;
                r_snap_sum[k] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_x <= w_x_nxt;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    r_cnt[k] <= r1_eop ? '0 : w_cnt_new[k];
                    r_sum[k] <= r1_eop ? '0 : w_sum_new[k];
                end
            end
            if (w_snap) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    r_snap_cnt[k] <= w_cnt_new[k];
                    r_snap_sum[k] <= w_sum_new[k];
                end
            end
        end
    end

    // Restoring divider: one quotient bit per cycle, dividend bits taken MSB first.
    logic [CIW-1:0]   r_cls_idx;
    logic [BW-1:0]    r_bit, w_bit_sel;
    logic [CNT_W-1:0] r_rem, w_rem_nxt, w_div_cnt;
    logic [XW-1:0]    r_quo, w_quo_nxt;
    logic [SW-1:0]    w_div_sum;
    logic [CNT_W:0]   w_trial;
    logic             w_ge, w_cnt_zero, w_cls_done, w_last_cls;
    logic [XW-1:0]    r_cent [NUM_CLASSES];

    assign w_div_cnt  = r_snap_cnt[r_cls_idx];
    assign w_div_sum  = r_snap_sum[r_cls_idx];
    assign w_bit_sel  = BW'(SW - 1) - r_bit;
    assign w_trial    = {r_rem, w_div_sum[w_bit_sel]};
    assign w_ge       = (w_trial >= {1'b0, w_div_cnt});
    assign w_rem_nxt  = w_ge ? CNT_W'(w_trial - {1'b0, w_div_cnt}) : CNT_W'(w_trial);
    assign w_quo_nxt  = XW'({r_quo, w_ge});
    assign w_cnt_zero = (w_div_cnt == '0);
    assign w_cls_done = w_div_run & (w_cnt_zero | (r_bit == BW'(SW - 1)));
    assign w_last_cls = (r_cls_idx == CIW'(NUM_CLASSES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cls_idx <= '0;
            r_bit     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) r_cent[k] <= '0;
        end else if (!w_div_run) begin
            r_cls_idx <= '0;
            r_bit     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
        end else if (w_cls_done) begin
            r_cent[r_cls_idx] <= w_cnt_zero ? '0 : w_quo_nxt;
            r_cls_idx         <= r_cls_idx + CIW'(1);
            r_bit             <= '0;
            r_rem             <= '0;
            r_quo             <= '0;
        end else begin
            r_bit <= r_bit + BW'(1);
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_eop_evt) w_state_nxt = S_DIV;
            S_DIV:   if (w_cls_done && w_last_cls) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_eop_evt ? S_DIV : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_div_run = 1'b0;
        w_latch   = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            S_DIV: begin
                w_div_run = 1'b1;
                w_drop    = w_eop_evt;
            end
            S_DONE:  w_latch = 1'b1;
            default: ;
        endcase
    end

    logic [NUM_CLASSES*CNT_W-1:0] r_counts;
    logic [NUM_CLASSES*XW-1:0]    r_centroid;
    logic                         r_frame_done, r_overrun;

    // Results are registered with the pulse so frame_done and the new values appear together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counts     <= '0;
            r_centroid   <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_latch;
            r_overrun    <= w_drop;
            if (w_latch) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    r_counts[k*CNT_W +: CNT_W] <= r_snap_cnt[k];
                    r_centroid[k*XW +: XW]     <= r_cent[k];
                end
            end
        end
    end

    assign counts     = r_counts;
    assign centroid_x = r_centroid;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_multi_colour_tracker.sv
// Scoreboard bench for multi_colour_tracker: directed pixels and frames push
// hand-computed expectations; a monitor pops them as the DUT presents results.
module tb_multi_colour_tracker;

    localparam int CB    = 4;
    localparam int NC    = 3;
    localparam int IMG_W = 320;
    localparam int CNT_W = 17;
    localparam int XW    = $clog2(IMG_W);
    localparam int PW    = 3 * CB;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid, in_ready, in_sop, in_eop;
    logic [PW-1:0]        in_data;
    logic [CB-1:0]        thresh;
    logic [NC-1:0]        class_en;
    logic [1:0]           mode;
    logic                 out_valid, out_ready, out_sop, out_eop;
    logic [PW-1:0]        out_data;
    logic [NC*CNT_W-1:0]  counts;
    logic [NC*XW-1:0]     centroid_x;
    logic                 frame_done, overrun;

    multi_colour_tracker #(
        .CHAN_BITS(CB), .NUM_CLASSES(NC), .IMG_W(IMG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .thresh(thresh), .class_en(class_en), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .counts(counts), .centroid_x(centroid_x),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          line;
        int          col;
        logic [PW-1:0] data;
        logic [PW-1:0] exp;
    } spot_t;

    typedef struct packed {
        logic [NC*CNT_W-1:0] cnt;
        logic [NC*XW-1:0]    cen;
    } res_t;

    spot_t           spots[$];
    logic [PW+1:0]   exp_q[$];
    res_t            res_q[$];
    int              n_checks = 0;
    int              n_err    = 0;
    int              n_done   = 0;
    int              n_ovr    = 0;
    res_t            res_exp;
    logic [PW+1:0]   beat_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: DUT produced a result with nothing expected", name);
    endtask

    function automatic res_t mk_res(input int c0, input int c1, input int c2,
                                    input int x0, input int x1, input int x2);
        res_t r;
        r.cnt = {CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
        r.cen = {XW'(x2), XW'(x1), XW'(x0)};
        return r;
    endfunction

    // Monitor: compares whatever the DUT presents against the head of the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("unexpected_pixel");
                else begin
                    beat_exp = exp_q.pop_front();
                    check("out_beat{sop,eop,data}", {out_sop, out_eop, out_data}, beat_exp);
                end
            end
            if (frame_done) begin
                n_done++;
                if (res_q.size() == 0) fail("unexpected_frame_done");
                else begin
                    res_exp = res_q.pop_front();
                    check("counts", counts, res_exp.cnt);
                    check("centroid_x", centroid_x, res_exp.cen);
                end
            end
            if (overrun) n_ovr++;
        end
    end

    task automatic send(input logic [PW-1:0] d, input logic s, input logic e,
                        input logic [PW-1:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        exp_q.push_back({s, e, exp});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Junk with sop/eop set is offered while stalled; none of it may be accepted.
    task automatic stall(input int n);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 12'hF00;
        in_sop    = 1'b1;
        in_eop    = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
    endtask

    task automatic add_spot(input int ln, input int c, input logic [PW-1:0] d,
                            input logic [PW-1:0] e);
        spot_t s;
        s.line = ln;
        s.col  = c;
        s.data = d;
        s.exp  = e;
        spots.push_back(s);
    endtask

    task automatic send_frame(input logic [PW-1:0] bg, input logic [PW-1:0] bg_exp,
                              input int stall_col);
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 0; c < IMG_W; c++) begin
                logic [PW-1:0] d;
                logic [PW-1:0] e;
                d = bg;
                e = bg_exp;
                foreach (spots[i]) begin
                    if (spots[i].line == ln && spots[i].col == c) begin
                        d = spots[i].data;
                        e = spots[i].exp;
                    end
                end
                if (ln == 0 && c == stall_col) stall(5);
                send(d, (ln == 0 && c == 0), (ln == 1 && c == IMG_W - 1), e);
            end
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("frame_done_pulses", n_done, target);
    endtask

    task automatic red_pair_frame();
        spots.delete();
        add_spot(0, 10, 12'hF00, 12'hF00);
        add_spot(0, 30, 12'hF00, 12'hF00);
        add_spot(1, 10, 12'hF00, 12'hF00);
        add_spot(1, 30, 12'hF00, 12'hF00);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = '0;
        thresh    = 4'd8;
        class_en  = 3'b111;
        mode      = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_follows_lo", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("rst_in_ready_follows_hi", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_counts", counts, 0);
        check("rst_centroid", centroid_x, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single pixels: latency, margin boundary, modes, no-wrap threshold.
        mode = 2'd1;
        send(12'hF00, 1'b0, 1'b0, 12'hF00);
        send(12'h880, 1'b0, 1'b0, 12'h000);
        check("latency_valid", out_valid, 1);
        check("latency_f00", out_data, 12'hF00);
        send(12'h900, 1'b0, 1'b0, 12'hF00);
        check("latency_880", out_data, 12'h000);
        send(12'h800, 1'b0, 1'b0, 12'h000);
        mode = 2'd2;
        send(12'h880, 1'b0, 1'b0, 12'h880);
        send(12'h2D1, 1'b0, 1'b0, 12'h0F0);
        send(12'h123, 1'b0, 1'b0, 12'h123);
        mode = 2'd0;
        send(12'h0F0, 1'b0, 1'b0, 12'h0F0);
        mode = 2'd3;
        send(12'h00F, 1'b0, 1'b0, 12'h00F);
        mode   = 2'd1;
        thresh = 4'd15;
        send(12'hF10, 1'b0, 1'b0, 12'h000);
        send(12'hF00, 1'b0, 1'b0, 12'h000);
        thresh = 4'd8;
        idle(4);

        // 320x2 frame, red at columns 10 and 30 of each line.
        red_pair_frame();
        res_q.push_back(mk_res(4, 0, 0, 20, 0, 0));
        send_frame(12'h123, 12'h000, -1);
        wait_done(1, 300);
        idle(20);
        check("counts_hold", counts, mk_res(4, 0, 0, 20, 0, 0).cnt);
        check("centroid_hold", centroid_x, mk_res(4, 0, 0, 20, 0, 0).cen);

        // Same frame with a 5-cycle stall mid-line between the red pixels.
        res_q.push_back(mk_res(4, 0, 0, 20, 0, 0));
        send_frame(12'h123, 12'h000, 20);
        wait_done(2, 300);

        // Blue disabled, truncating divides, highlight mode.
        class_en = 3'b011;
        mode     = 2'd2;
        spots.delete();
        add_spot(0, 1,   12'hC21, 12'hF00);
        add_spot(1, 300, 12'hC21, 12'hF00);
        add_spot(0, 100, 12'h2D1, 12'h0F0);
        add_spot(1, 101, 12'h2D1, 12'h0F0);
        add_spot(1, 5,   12'h2D1, 12'h0F0);
        add_spot(0, 7,   12'h00F, 12'h00F);
        add_spot(1, 7,   12'h00F, 12'h00F);
        res_q.push_back(mk_res(2, 3, 0, 150, 68, 0));
        send_frame(12'h123, 12'h123, -1);
        wait_done(3, 300);
        class_en = 3'b111;

        // Second eop during the divide: dropped with an overrun pulse.
        mode = 2'd1;
        red_pair_frame();
        res_q.push_back(mk_res(4, 0, 0, 20, 0, 0));
        send_frame(12'h123, 12'h000, -1);
        idle(9);
        send(12'h0F0, 1'b1, 1'b1, 12'h0F0);
        wait_done(4, 300);
        idle(5);
        check("overrun_pulses", n_ovr, 1);

        // Reset in the middle of a divide aborts it without a frame_done.
        send_frame(12'h123, 12'h000, -1);
        idle(20);
        reset = 1'b1;
        #1;
        check("abort_counts", counts, 0);
        check("abort_centroid", centroid_x, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_frame_done", frame_done, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(150);
        check("no_done_after_abort", n_done, 4);

        spots.delete();
        add_spot(0, 40, 12'h2D1, 12'h0F0);
        add_spot(1, 60, 12'h2D1, 12'h0F0);
        res_q.push_back(mk_res(0, 2, 0, 0, 50, 0));
        send_frame(12'h123, 12'h000, -1);
        wait_done(5, 300);

        idle(10);
        check("pixel_queue_drained", exp_q.size(), 0);
        check("result_queue_drained", res_q.size(), 0);
        check("total_frame_done", n_done, 5);
        check("total_overrun", n_ovr, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
